// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32I pipeline front end.
//   XLEN / INSTR_W : datapath and instruction widths
//   NOP_INSTR      : value presented on the instruction bus when nothing is valid
//   fetch_entry_t  : one instruction-queue entry {instr, pc}
//   word_align()   : clears the two low address bits of a fetch target
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear.
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : empties the FIFO next cycle (wins over push/pop)
//   push/push_data : write one entry at the tail
//   pop          : remove the head entry
//   head_data    : current head entry (valid when !empty)
//   count/full/empty : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == CW'(0));
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = PW'(0);
      wr_ptr_d = PW'(0);
      count_d  = CW'(0);
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= PW'(0);
      wr_ptr_q <= PW'(0);
      count_q  <= CW'(0);
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end of the 5-stage RV32I pipeline.
//   clk, reset            : clock, asynchronous active-high reset
//   imem_req_*            : sequential fetch requests (valid/ready/addr)
//   imem_resp_*           : in-order responses, one per accepted request
//   redirect, redirect_pc : taken branch/jump target from execute
//   stall                 : decode stall, holds the presented instruction
//   instr_valid/instr/instr_pc/instr_pc_plus4 : head of the instruction queue
// A request is only issued when a queue slot is reserved for its response,
// so responses never need backpressure. After a redirect every response
// still in flight is counted in drop_q and discarded on arrival.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  // wide enough to hold queue count + outstanding without overflow
  localparam int CW  = $clog2(DEPTH) + 2;
  localparam int QCW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;   // PC of the next kept response
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [QCW-1:0]  q_count;
  logic            q_full, q_empty;
  logic            q_push, q_pop;
  fetch_entry_t    q_in, q_head;
  logic [CW-1:0]   slots_used;
  logic            req_ok, req_fire;
  logic            resp_ok, resp_discard;

  // queue slots already claimed: stored entries plus responses still to be kept
  assign slots_used   = CW'(q_count) + outstanding_q - drop_q;
  assign req_ok       = !reset && !redirect &&
                        (outstanding_q < CW'(MAX_OUTSTANDING)) &&
                        (slots_used < CW'(DEPTH));
  assign req_fire     = req_ok && imem_req_ready;
  // responses with nothing outstanding are spurious and ignored
  assign resp_ok      = imem_resp_valid && (outstanding_q != CW'(0));
  assign resp_discard = (drop_q != CW'(0)) || redirect;
  assign q_push       = resp_ok && !resp_discard;
  assign q_pop        = !q_empty && !stall && !redirect;
  assign q_in         = '{instr: imem_resp_data, pc: resp_pc_q};

  assign imem_req_valid = req_ok;
  assign imem_req_addr  = fetch_pc_q;

  // next-state for fetch address, response PC and in-flight bookkeeping
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
    drop_d        = drop_q;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      // everything still in flight after this cycle belongs to the old path
      drop_d     = outstanding_q - CW'(resp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (q_push) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end else begin
        resp_pc_d = resp_pc_q;
      end
      if (resp_ok && (drop_q != CW'(0))) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= CW'(0);
      drop_q        <= CW'(0);
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_iq (
    .clk      (clk),
    .reset    (reset),
    .clear    (redirect),
    .push     (q_push),
    .push_data(q_in),
    .pop      (q_pop),
    .head_data(q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // head is presented straight from the queue registers, zeroed when empty
  always_comb begin
    instr_valid = !q_empty;
    if (!q_empty) begin
      instr          = q_head.instr;
      instr_pc       = q_head.pc;
      instr_pc_plus4 = q_head.pc + 32'd4;
    end else begin
      instr          = NOP_INSTR;
      instr_pc       = 32'h0000_0000;
      instr_pc_plus4 = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The memory model returns data = addr ^ 32'h1357_0000 after a fixed
// latency (lat cycles); expected PCs and addresses are written out by hand.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  int          n_total;
  int          n_bad;
  int          cyc;
  int          lat;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        last_rv;
  logic [31:0] last_ra;

  fetch_unit #(
    .DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock cycle: drive the due response, record the request, advance
  task automatic step();
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_addr[0] ^ 32'h1357_0000;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0000_0000;
    end
    #1;
    last_rv = imem_req_valid;
    last_ra = imem_req_addr;
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_resp_valid = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_instr"}, instr, pc ^ 32'h1357_0000);
    chk({tag, "_pc4"}, instr_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    cyc = 0;
    lat = 1;
    reset = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0000_0000;
    redirect = 1'b0;
    redirect_pc = 32'h0000_0000;
    stall = 1'b0;
    #3;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_pc", instr_pc, 32'h0000_0000);
    chk("rst_pc4", instr_pc_plus4, 32'h0000_0000);

    // ---- streaming, latency 1 ----
    do_reset();
    step();
    chk("s_req0_v", {31'd0, last_rv}, 32'd1);
    chk("s_req0_a", last_ra, 32'h0000_0000);
    chk("s_empty0", {31'd0, instr_valid}, 32'd0);
    step();
    chk("s_req1_a", last_ra, 32'h0000_0004);
    chk_out("s_i0", 32'h0000_0000);
    step();
    chk("s_req2_a", last_ra, 32'h0000_0008);
    chk_out("s_i1", 32'h0000_0004);
    step();
    chk_out("s_i2", 32'h0000_0008);

    // ---- stall 3 cycles, queue fills ----
    stall = 1'b1;
    step();
    chk_out("st_a", 32'h0000_0008);
    step();
    chk_out("st_b", 32'h0000_0008);
    step();
    chk("st_c_req", {31'd0, last_rv}, 32'd0);
    chk_out("st_c", 32'h0000_0008);
    stall = 1'b0;
    step();
    chk("st_d_req", {31'd0, last_rv}, 32'd0);
    chk_out("st_d", 32'h0000_000C);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("st_rel", 32'h0000_0010 + 32'(i) * 32'd4);
    end

    // ---- redirect with 2 in flight, latency 2 ----
    lat = 2;
    do_reset();
    step();
    chk("r_req0", last_ra, 32'h0000_0000);
    step();
    chk("r_req1", last_ra, 32'h0000_0004);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    chk("r_redir_req", {31'd0, last_rv}, 32'd0);
    chk("r_c2_valid", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b0;
    step();
    chk("r_req_tgt_v", {31'd0, last_rv}, 32'd1);
    chk("r_req_tgt_a", last_ra, 32'h0000_0100);
    chk("r_c3_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("r_c4_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk_out("r_c5", 32'h0000_0100);
    step();
    chk_out("r_c6", 32'h0000_0104);

    // ---- ready toggling 1,0,0,1 ----
    imem_req_ready = 1'b1;
    step();
    chk("rdy_c7_a", last_ra, 32'h0000_010C);
    chk("rdy_c7_valid", {31'd0, instr_valid}, 32'd0);
    imem_req_ready = 1'b0;
    step();
    chk("rdy_c8_a", last_ra, 32'h0000_0110);
    chk_out("rdy_c8", 32'h0000_0108);
    step();
    chk("rdy_c9_v", {31'd0, last_rv}, 32'd1);
    chk("rdy_c9_a", last_ra, 32'h0000_0110);
    chk_out("rdy_c9", 32'h0000_010C);
    imem_req_ready = 1'b1;
    step();
    chk("rdy_c10_a", last_ra, 32'h0000_0110);
    step();
    chk("rdy_c11_a", last_ra, 32'h0000_0114);

    // ---- redirect + response + stall, unaligned target ----
    redirect = 1'b1;
    stall = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    chk("rs_req", {31'd0, last_rv}, 32'd0);
    chk("rs_valid", {31'd0, instr_valid}, 32'd0);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    chk("rs_tgt_a", last_ra, 32'h0000_0200);
    chk("rs_c13_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("rs_c14_a", last_ra, 32'h0000_0204);
    chk("rs_c14_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk_out("rs_c15", 32'h0000_0200);

    // ---- fill queue under stall, then async reset ----
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
    end
    chk("full_req", {31'd0, last_rv}, 32'd0);
    chk_out("full_hold", 32'h0000_0200);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("ar_req_addr", imem_req_addr, 32'h0000_0000);
    chk("ar_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_instr", instr, 32'h0000_0000);
    chk("ar_pc", instr_pc, 32'h0000_0000);
    chk("ar_pc4", instr_pc_plus4, 32'h0000_0000);
    stall = 1'b0;
    lat = 1;
    do_reset();
    step();
    chk("ar_restart_v", {31'd0, last_rv}, 32'd1);
    chk("ar_restart_a", last_ra, 32'h0000_0000);
    step();
    chk_out("ar_i0", 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
